// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner (state enum, key code width).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package keypad_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_t;

  // Index of the lowest set bit; the lowest row wins when several rows are active.
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Index of a one-hot column drive.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Next column in the scan rotation 0001->0010->0100->1000->0001.
  function automatic logic [3:0] next_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Latency: 2 clk cycles from d to q.
// Backpressure: none (free-running sampler).
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops; only q is used downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner with press/release debounce; auto-repeat when KEYPAD_SCAN_REPEAT_EN is defined.
// Latency: 2-cycle row sync, then DEBOUNCE_CYCLES stable cycles to accept a press or a release.
// Backpressure: none; key_valid is a one-cycle pulse that is never held off.
module keypad_scan4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int REPEAT_CYCLES   = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             key_held
);

  // Reject parameter values the 16-bit counters cannot represent.
  if (SCAN_DIV < 4 || SCAN_DIV > 65535 ||
      DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES > 65535) begin : g_param_check
    $error("keypad_scan4x4: parameter out of legal range");
  end

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] DB_LAST    = 16'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  rs;        // synchronized row sense
  kp_state_t   state;
  logic [15:0] dwell;     // cycles the current column has been driven
  logic [15:0] cnt;       // debounce counter (press stability or release stability)
  logic [1:0]  cap_row;   // row index of the locked candidate key
  logic [1:0]  cap_col;   // column index of the locked candidate key

`ifdef KEYPAD_SCAN_REPEAT_EN
  localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);
  logic [15:0] rep_cnt;   // cycles since the last key_valid while held
`endif

  sync_2ff #(
    .W(4)
  ) u_row_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (row),
    .q    (rs)
  );

  // Scan / debounce / hold state machine; every output is registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SCAN;
      col       <= 4'b0001;
      dwell     <= '0;
      cnt       <= '0;
      cap_row   <= '0;
      cap_col   <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          // Rows are only trusted on the last dwell cycle, after the column
          // drive has had time to propagate through the synchronizer.
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (rs != 4'b0000) begin
              cap_row <= lowest_idx(rs);
              cap_col <= onehot_idx(col);
              cnt     <= '0;
              state   <= DEBOUNCE;
            end else begin
              col <= next_col(col);
            end
          end else begin
            dwell <= dwell + 16'd1;
          end
        end

        DEBOUNCE: begin
          // Column stays frozen so only the locked key can be seen.
          if (rs[cap_row]) begin
            if (cnt == DB_LAST) begin
              key       <= {cap_row, cap_col};
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              cnt       <= '0;
              state     <= HELD;
`ifdef KEYPAD_SCAN_REPEAT_EN
              rep_cnt   <= '0;
`endif
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else begin
            // Bounce or release before acceptance: resume on the next column.
            cnt   <= '0;
            dwell <= '0;
            col   <= next_col(col);
            state <= SCAN;
          end
        end

        HELD: begin
          // Release must be quiet for the full debounce window; any activity restarts it.
          if (rs == 4'b0000) begin
            if (cnt == DB_LAST) begin
              key_held <= 1'b0;
              cnt      <= '0;
              dwell    <= '0;
              col      <= next_col(col);
              state    <= SCAN;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else begin
            cnt <= '0;
          end
`ifdef KEYPAD_SCAN_REPEAT_EN
          // Repeat timer free-runs in HELD; a pulse is emitted only if the key is still down.
          if (rep_cnt == REP_LAST) begin
            rep_cnt   <= '0;
            key_valid <= (rs != 4'b0000);
          end else begin
            rep_cnt <= rep_cnt + 16'd1;
          end
`endif
        end

        default: begin
          state <= SCAN;
          col   <= 4'b0001;
          dwell <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan4x4.sv
module tb_keypad_scan4x4;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int RP = 20;
`ifdef KEYPAD_SCAN_REPEAT_EN
  localparam int EXP_REP_PULSES = 4;  // initial pulse plus 3 repeats in 70 cycles
`else
  localparam int EXP_REP_PULSES = 1;
`endif

  localparam int PH_SCAN = 0;
  localparam int PH_CONF = 1;
  localparam int PH_HOLD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  // Keypad matrix: a pressed switch connects its column drive to its row.
  bit         pressed [4][4];
  bit         force_en = 1'b1;
  logic [3:0] force_val = 4'b1111;

  int total = 0;
  int bad   = 0;
  int cyc_no = 0;
  int pulse_cnt = 0;
  int pulse_q[$];

  // Behavioural model state
  bit         model_ready = 1'b0;
  int         m_phase, m_col, m_age, m_run, m_rep, m_row;
  logic [3:0] m_d1, m_d2, m_key;
  logic       m_kv, m_held;

  keypad_scan4x4 #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'b0000;
    if (force_en) begin
      row = force_val;
    end else begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (pressed[r][c] && col[c] === 1'b1) row[r] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // One clock of the keypad's behaviour, described as phases and run lengths.
  task automatic model_step(input logic [3:0] r_in, input logic rst_in);
    logic [3:0] seen;
    if (rst_in !== 1'b1) begin
      model_ready = 1'b1;
      m_d1 = 4'b0; m_d2 = 4'b0;
      m_phase = PH_SCAN; m_col = 0; m_age = 0; m_run = 0; m_rep = 0; m_row = 0;
      m_key = 4'b0; m_kv = 1'b0; m_held = 1'b0;
    end else begin
      seen = m_d2;          // rows as seen two clocks after the pins
      m_d2 = m_d1;
      m_d1 = r_in;
      m_kv = 1'b0;
      if (m_phase == PH_SCAN) begin
        if (m_age == SD - 1) begin
          m_age = 0;
          if (seen != 4'b0) begin
            m_row = 3;
            for (int i = 3; i >= 0; i--) if (seen[i]) m_row = i;
            m_phase = PH_CONF;
            m_run = 0;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end else begin
          m_age++;
        end
      end else if (m_phase == PH_CONF) begin
        if (seen[m_row]) begin
          m_run++;
          if (m_run == DB) begin
            m_key = 4'(m_row * 4 + m_col);
            m_kv = 1'b1;
            m_held = 1'b1;
            m_phase = PH_HOLD;
            m_run = 0;
            m_rep = 0;
          end
        end else begin
          m_phase = PH_SCAN;
          m_col = (m_col + 1) % 4;
          m_age = 0;
        end
      end else begin
        if (seen == 4'b0) begin
          m_run++;
          if (m_run == DB) begin
            m_held = 1'b0;
            m_phase = PH_SCAN;
            m_col = (m_col + 1) % 4;
            m_age = 0;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
`ifdef KEYPAD_SCAN_REPEAT_EN
        m_rep++;
        if (m_rep == RP) begin
          m_rep = 0;
          if (seen != 4'b0) m_kv = 1'b1;
        end
`endif
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(row, rst_n);
  end

  // Compare every output against the model on the falling edge.
  initial forever begin
    @(negedge clk);
    cyc_no++;
    if (model_ready) begin
      chk("col",       32'(col),       32'(1 << m_col));
      chk("key",       32'(key),       32'(m_key));
      chk("key_valid", 32'(key_valid), 32'(m_kv));
      chk("key_held",  32'(key_held),  32'(m_held));
      if (key_valid === 1'b1) begin
        pulse_cnt++;
        pulse_q.push_back(cyc_no);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_held(input logic v, input int budget, input string name, output int waited);
    waited = 0;
    while (key_held !== v && waited < budget) begin
      cyc(1);
      waited++;
    end
    if (key_held !== v) begin
      total++;
      bad++;
      $display("FAIL %s: timed out, key_held=%b expected %b after %0d cycles", name, key_held, v, waited);
    end
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;

    // Reset with every row active
    rst_n = 1'b0;
    force_en = 1'b1;
    force_val = 4'b1111;
    cyc(3);
    chk("rst_col",   32'(col),       32'h1);
    chk("rst_key",   32'(key),       32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_held",  32'(key_held),  32'h0);
    rst_n = 1'b1;
    force_en = 1'b0;
    cyc(2);

    // Clean press of row 2 / column 2
    pulse_cnt = 0;
    pressed[2][2] = 1'b1;
    wait_held(1'b1, 100, "press_accept", w);
    cyc(40);
    chk("press_pulses", 32'(pulse_cnt), 32'd1);
    chk("press_key",    32'(key),       32'hA);
    chk("press_held",   32'(key_held),  32'h1);
    pressed[2][2] = 1'b0;
    wait_held(1'b0, 60, "press_release", w);
    chk("release_latency", 32'(w),   32'd10);
    chk("release_col",     32'(col), 32'h8);
    chk("release_key",     32'(key), 32'hA);

    // Bouncing contact on row 1 / column 1
    pulse_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      pressed[1][1] = ~pressed[1][1];
      cyc(3);
    end
    pressed[1][1] = 1'b0;
    cyc(12);
    chk("bounce_pulses", 32'(pulse_cnt), 32'd0);
    chk("bounce_held",   32'(key_held),  32'h0);

    // Two rows in column 0, then a locked-out key in column 3
    pulse_cnt = 0;
    pressed[1][0] = 1'b1;
    pressed[2][0] = 1'b1;
    wait_held(1'b1, 100, "multi_accept", w);
    cyc(2);
    pressed[3][3] = 1'b1;
    cyc(20);
    chk("multi_key",    32'(key),       32'h4);
    chk("multi_pulses", 32'(pulse_cnt), 32'd1);
    chk("multi_col",    32'(col),       32'h1);
    pressed[3][3] = 1'b0;
    cyc(3);
    pressed[1][0] = 1'b0;
    pressed[2][0] = 1'b0;
    wait_held(1'b0, 60, "multi_release", w);
    chk("multi_rel_col", 32'(col), 32'h2);
    chk("multi_rel_key", 32'(key), 32'h4);

    // Key F held 70 cycles past acceptance
    pulse_q.delete();
    pressed[3][3] = 1'b1;
    wait_held(1'b1, 100, "rep_accept", w);
    cyc(70);
    chk("rep_pulses", 32'(pulse_q.size()), 32'(EXP_REP_PULSES));
    chk("rep_key",    32'(key),            32'hF);
`ifdef KEYPAD_SCAN_REPEAT_EN
    if (pulse_q.size() == EXP_REP_PULSES) begin
      for (int i = 0; i + 1 < EXP_REP_PULSES; i++)
        chk("rep_spacing", 32'(pulse_q[i+1] - pulse_q[i]), 32'd20);
    end
`endif
    pressed[3][3] = 1'b0;
    wait_held(1'b0, 60, "rep_release", w);

    // Reset while a press of row 0 / column 1 is being debounced
    pressed[0][1] = 1'b1;
    n = 0;
    while (m_phase != PH_CONF && n < 100) begin
      cyc(1);
      n++;
    end
    if (m_phase != PH_CONF) begin
      total++;
      bad++;
      $display("FAIL midrst_wait: debounce not entered after %0d cycles", n);
    end
    cyc(3);
    pulse_cnt = 0;
    rst_n = 1'b0;
    pressed[0][1] = 1'b0;
    cyc(2);
    chk("midrst_col",   32'(col),      32'h1);
    chk("midrst_key",   32'(key),      32'h0);
    chk("midrst_held",  32'(key_held), 32'h0);
    rst_n = 1'b1;
    cyc(30);
    chk("midrst_pulses", 32'(pulse_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
